// File: rtl/fifo_sync_flags_pkg.sv
// Shared FIFO definitions: default geometry, log2 helper, pointer compares and
// the per-cycle operation encoding used by the FIFO variants.
package fifo_sync_flags_pkg;

    localparam int DEF_FIFO_W    = 8;
    localparam int DEF_FIFO_D    = 8;
    localparam int DEF_AF_THRESH = 6;
    localparam int DEF_AE_THRESH = 2;

    // {write accepted, read accepted}
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    // Pointers carry one wrap bit above addr_w address bits.
    function automatic logic ptrs_empty(input logic [31:0] wr, input logic [31:0] rd);
        return wr == rd;
    endfunction

    function automatic logic ptrs_full(input logic [31:0] wr, input logic [31:0] rd,
                                       input int addr_w);
        logic [31:0] mask;
        mask = (32'd1 << addr_w) - 32'd1;
        return (((wr ^ rd) & mask) == 32'd0) && (wr[addr_w] != rd[addr_w]);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: FIFO_D x FIFO_W flop array, one synchronous write port and
// one asynchronous read port.
module fifo_mem #(
    parameter int FIFO_W = 8,
    parameter int FIFO_D = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk_i,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [FIFO_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [FIFO_W-1:0] rd_data
);

    logic [FIFO_W-1:0] mem [FIFO_D];

    // NOTE: storage has no reset; the empty/full flags guard every read, so
    // stale contents are never observed and a reset tree is not needed here.
    always_ff @(posedge clk_i) begin
        if (write_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with fill count, almost flags and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module fifo_sync_flags
    import fifo_sync_flags_pkg::*;
#(
    parameter int FIFO_W    = DEF_FIFO_W,
    parameter int FIFO_D    = DEF_FIFO_D,
    parameter int AF_THRESH = DEF_AF_THRESH,
    parameter int AE_THRESH = DEF_AE_THRESH
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      write_en,
    input  logic [FIFO_W-1:0]         data_in,
    input  logic                      read_en,
    input  logic                      clr_err_i,
    output logic [FIFO_W-1:0]         data_out,
    output logic                      data_valid,
    output logic                      empty,
    output logic                      full,
    output logic                      almost_empty,
    output logic                      almost_full,
    output logic [clog2(FIFO_D):0]    count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int ADDR_W = clog2(FIFO_D);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] AF_CNT = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_CNT = CNT_W'(AE_THRESH);

    logic [CNT_W-1:0]  wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next, count_next;
    logic [FIFO_W-1:0] rd_data;
    logic              wr_ok, rd_ok;
    fifo_op_e          op;

    // Full blocks writes even when a read frees a slot in the same cycle.
    assign wr_ok = write_en && !full;
    assign rd_ok = read_en && !empty;
    assign op    = fifo_op_e'({wr_ok, rd_ok});

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        count_next  = count;
        case (op)
            OP_WR: begin
                wr_ptr_next = wr_ptr + 1'b1;
                count_next  = count + 1'b1;
            end
            OP_RD: begin
                rd_ptr_next = rd_ptr + 1'b1;
                count_next  = count - 1'b1;
            end
            OP_BOTH: begin
                wr_ptr_next = wr_ptr + 1'b1;
                rd_ptr_next = rd_ptr + 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_next;
            rd_ptr       <= rd_ptr_next;
            count        <= count_next;
            empty        <= ptrs_empty(32'(wr_ptr_next), 32'(rd_ptr_next));
            full         <= ptrs_full(32'(wr_ptr_next), 32'(rd_ptr_next), ADDR_W);
            almost_empty <= count_next <= AE_CNT;
            almost_full  <= count_next >= AF_CNT;
        end
    end

    // Sticky errors: a set in the same cycle as a clear takes priority.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write_en && full) overflow <= 1'b1;
            else if (clr_err_i)   overflow <= 1'b0;
            if (read_en && empty) underflow <= 1'b1;
            else if (clr_err_i)   underflow <= 1'b0;
        end
    end

    fifo_mem #(
        .FIFO_W (FIFO_W),
        .FIFO_D (FIFO_D),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_i   (clk_i),
        .write_en(wr_ok),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (data_in),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (rd_data)
    );

`ifdef FIFO_FWFT_EN
    assign data_out   = empty ? '0 : rd_data;
    assign data_valid = !empty;
`else
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= rd_ok;
            if (rd_ok) data_out <= rd_data;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Self-checking bench for fifo_sync_flags (FIFO_W=8, FIFO_D=8, AF=6, AE=2):
// scripted vector table plus multi-cycle sequences, checked against a queue model.
module tb_fifo_sync_flags;

    logic       clk_i = 1'b0;
    logic       rst_i, write_en, read_en, clr_err_i;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_valid, empty, full, almost_empty, almost_full, overflow, underflow;
    logic [3:0] count;

    fifo_sync_flags #(
        .FIFO_W(8), .FIFO_D(8), .AF_THRESH(6), .AE_THRESH(2)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .write_en    (write_en),
        .data_in     (data_in),
        .read_en     (read_en),
        .clr_err_i   (clr_err_i),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .empty       (empty),
        .full        (full),
        .almost_empty(almost_empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard: words pushed on accepted writes, popped on accepted reads.
    logic [7:0] mq[$];
    logic       m_ovf = 1'b0, m_unf = 1'b0, m_dv = 1'b0;
    logic [7:0] m_dout = 8'h00;

    typedef struct {
        logic       we;
        logic [7:0] din;
        logic       re;
        logic       clr;
        int         exp_count;
        logic       exp_ovf;
        logic       exp_unf;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_update(input logic rst, input logic we, input logic [7:0] din,
                                input logic re, input logic clr);
        logic full_m, empty_m, wr_ok, rd_ok;
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0; m_unf = 1'b0; m_dv = 1'b0; m_dout = 8'h00;
        end else begin
            full_m  = (mq.size() == 8);
            empty_m = (mq.size() == 0);
            wr_ok   = we && !full_m;
            rd_ok   = re && !empty_m;
            m_dv    = rd_ok;
            if (rd_ok) m_dout = mq.pop_front();
            if (wr_ok) mq.push_back(din);
            if (we && full_m) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
            if (re && empty_m) m_unf = 1'b1; else if (clr) m_unf = 1'b0;
        end
    endtask

    task automatic compare_all(input string tag);
        int n;
        n = mq.size();
        check({tag, ".count"},        32'(count),        n);
        check({tag, ".empty"},        32'(empty),        int'(n == 0));
        check({tag, ".full"},         32'(full),         int'(n == 8));
        check({tag, ".almost_empty"}, 32'(almost_empty), int'(n <= 2));
        check({tag, ".almost_full"},  32'(almost_full),  int'(n >= 6));
        check({tag, ".overflow"},     32'(overflow),     32'(m_ovf));
        check({tag, ".underflow"},    32'(underflow),    32'(m_unf));
`ifdef FIFO_FWFT_EN
        check({tag, ".data_valid"},   32'(data_valid),   int'(n != 0));
        check({tag, ".data_out"},     32'(data_out),     (n != 0) ? 32'(mq[0]) : 0);
`else
        check({tag, ".data_valid"},   32'(data_valid),   32'(m_dv));
        check({tag, ".data_out"},     32'(data_out),     32'(m_dout));
`endif
    endtask

    // Drive one cycle, advance the model across the edge, then sample 1 ns later.
    task automatic step(input string tag, input logic rst, input logic we,
                        input logic [7:0] din, input logic re, input logic clr);
        rst_i = rst; write_en = we; data_in = din; read_en = re; clr_err_i = clr;
        @(posedge clk_i);
        model_update(rst, we, din, re, clr);
        #1;
        compare_all(tag);
    endtask

    initial begin
        // Vector table: fill, overflow + clear, drain, underflow, set-vs-clear priority.
        for (int i = 0; i < 8; i++)
            vecs[i] = '{1'b1, 8'(8'h11 + i), 1'b0, 1'b0, i + 1, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 8'hAA, 1'b0, 1'b0, 8, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 8, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++)
            vecs[10 + i] = '{1'b0, 8'h00, 1'b1, 1'b0, 7 - i, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1};
        vecs[19] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b0, 1'b1};
        vecs[21] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0};

        rst_i = 1'b1; write_en = 1'b0; read_en = 1'b0; clr_err_i = 1'b0; data_in = 8'h00;
        step("reset", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step("reset", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check("reset.count_const", 32'(count), 0);
        check("reset.empty_const", 32'(empty), 1);

        foreach (vecs[i]) begin
            step($sformatf("tbl[%0d]", i), 1'b0, vecs[i].we, vecs[i].din, vecs[i].re, vecs[i].clr);
            check($sformatf("tbl[%0d].exp_count", i), 32'(count), vecs[i].exp_count);
            check($sformatf("tbl[%0d].exp_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
            check($sformatf("tbl[%0d].exp_unf", i), 32'(underflow), 32'(vecs[i].exp_unf));
        end

        // Steady state at count 4 with pointers wrapping several times.
        for (int i = 0; i < 4; i++) step("ss_fill", 1'b0, 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step("ss_rw", 1'b0, 1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
            check("ss_rw.count4", 32'(count), 4);
        end
        // Full: simultaneous read is accepted, write rejected and flagged.
        for (int i = 0; i < 4; i++) step("full_fill", 1'b0, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        check("full_fill.full", 32'(full), 1);
        step("full_rw", 1'b0, 1'b1, 8'hEE, 1'b1, 1'b0);
        check("full_rw.count7", 32'(count), 7);
        check("full_rw.overflow", 32'(overflow), 1);
        while (mq.size() != 0) step("drain", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step("clr", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // Reset mid-stream with requests present in the reset cycle.
        for (int i = 0; i < 5; i++) step("mid_fill", 1'b0, 1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        step("mid_rst", 1'b1, 1'b1, 8'h99, 1'b1, 1'b1);
        check("mid_rst.count0", 32'(count), 0);
        check("mid_rst.empty1", 32'(empty), 1);
        step("post_wr", 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
`ifdef FIFO_FWFT_EN
        check("fwft.data_out", 32'(data_out), 32'h5A);
        check("fwft.valid", 32'(data_valid), 1);
        step("post_rd", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("fwft.empty_after_pop", 32'(empty), 1);
        step("fwft_wr", 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
        check("fwft.data_3c", 32'(data_out), 32'h3C);
        check("fwft.empty0", 32'(empty), 0);
        step("fwft_pop", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("fwft.empty1", 32'(empty), 1);
`else
        step("post_rd", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("post_rd.data_5a", 32'(data_out), 32'h5A);
        check("post_rd.valid", 32'(data_valid), 1);
        step("idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("idle.valid0", 32'(data_valid), 0);
        check("idle.data_hold", 32'(data_out), 32'h5A);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
